fetch_stage: RTL and testbench

// - IF stage of the 5-stage RV32I pipeline. Owns the PC and issues word fetches on the imem port.
// - Drives if_id_stage_reg_t plus the fetched instruction word into the IF/ID register, feeding decode.
// - Supports downstream stall (back-pressure) and flush/redirect from EX (taken branch, jal, jalr).
// - At most one imem request is outstanding at any time.

---
 rtl/fetch_stage_pkg.sv | 27 ++
 rtl/fetch_stage_hold_buf.sv | 32 +++
 rtl/fetch_stage.sv | 145 ++++++++++++++
 tb/tb_fetch_stage.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types for the RV32I fetch stage: FSM state encoding, the IF/ID
// payload struct and the sequential-PC helper.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1eceb000;
    localparam logic [3:0]  RMASK_WORD       = 4'b1111;
    localparam logic [3:0]  RMASK_IDLE       = 4'b0000;

    typedef enum logic [1:0] {
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_HOLD,
        FETCH_DROP
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc_s;
        logic [31:0] pc_next_s;
        logic        valid_s;
    } if_id_stage_reg_t;

    // Sequential successor; wraps modulo 2^32 with no exception.
    function automatic logic [31:0] next_word(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_hold_buf.sv
// One-entry {pc, inst} buffer that keeps a fetched word while decode stalls,
// so imem_rdata need not stay stable after its response pulse.
module fetch_hold_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_inst,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] inst
);

    // Clear wins over load so a redirect can never resurrect a stale word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= 32'h0;
            inst  <= 32'h0;
        end else if (clear) begin
            valid <= 1'b0;
            pc    <= 32'h0;
            inst  <= 32'h0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            inst  <= load_inst;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage RV32I pipeline: owns the PC, issues one word fetch
// at a time on imem, and presents {pc, pc+4, valid} plus inst to decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      imem_addr,
    output logic [3:0]       imem_rmask,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_resp,
    output if_id_stage_reg_t if_id,
    output logic [31:0]      inst
);

    // Handshakes: a request is live while imem_rmask=4'hf and becomes
    // outstanding at the first clock edge it is presented in REQ; imem_resp
    // pulses once to complete it. Toward decode, valid_s=1 offers a word and
    // stall=1 means it was not taken, so it is held bit-for-bit until stall=0.
    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc_inc;
    logic [31:0]  target;
    logic         buf_load;
    logic         buf_clear;
    logic         buf_valid;
    logic [31:0]  buf_pc;
    logic [31:0]  buf_inst;

    assign pc_inc = next_word(pc);
    assign target = redirect_pc & ~32'h3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH_REQ;
            pc         <= RESET_PC;
            imem_addr  <= RESET_PC;
            imem_rmask <= RMASK_IDLE;
        end else begin
            unique case (state)
                FETCH_REQ: begin
                    if (flush) begin
                        pc         <= target;
                        imem_addr  <= target;
                        imem_rmask <= RMASK_WORD;
                    end else if (imem_rmask == RMASK_WORD) begin
                        state <= FETCH_WAIT;
                    end else begin
                        // First cycle out of reset: present the request now.
                        imem_addr  <= pc;
                        imem_rmask <= RMASK_WORD;
                    end
                end
                FETCH_WAIT: begin
                    if (flush) begin
                        pc <= target;
                        if (imem_resp) begin
                            state     <= FETCH_REQ;
                            imem_addr <= target;
                        end else begin
                            state <= FETCH_DROP;
                        end
                    end else if (imem_resp) begin
                        if (stall) begin
                            state      <= FETCH_HOLD;
                            imem_rmask <= RMASK_IDLE;
                        end else begin
                            state     <= FETCH_REQ;
                            pc        <= pc_inc;
                            imem_addr <= pc_inc;
                        end
                    end
                end
                FETCH_HOLD: begin
                    if (flush) begin
                        state      <= FETCH_REQ;
                        pc         <= target;
                        imem_addr  <= target;
                        imem_rmask <= RMASK_WORD;
                    end else if (!stall) begin
                        state      <= FETCH_REQ;
                        pc         <= pc_inc;
                        imem_addr  <= pc_inc;
                        imem_rmask <= RMASK_WORD;
                    end
                end
                FETCH_DROP: begin
                    // The stale response still has to be absorbed before a new request.
                    if (flush) begin
                        pc <= target;
                        if (imem_resp) begin
                            state     <= FETCH_REQ;
                            imem_addr <= target;
                        end
                    end else if (imem_resp) begin
                        state     <= FETCH_REQ;
                        imem_addr <= pc;
                    end
                end
            endcase
        end
    end

    assign buf_load  = (state == FETCH_WAIT) && imem_resp && stall && !flush;
    assign buf_clear = flush || ((state == FETCH_HOLD) && !stall);

    fetch_hold_buf u_hold_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (buf_load),
        .clear     (buf_clear),
        .load_pc   (pc),
        .load_inst (imem_rdata),
        .valid     (buf_valid),
        .pc        (buf_pc),
        .inst      (buf_inst)
    );

    always_comb begin
        if_id = '0;
        inst  = 32'h0;
        if (!flush && (state == FETCH_WAIT) && imem_resp) begin
            if_id.pc_s      = pc;
            if_id.pc_next_s = pc_inc;
            if_id.valid_s   = 1'b1;
            inst            = imem_rdata;
        end else if (!flush && (state == FETCH_HOLD) && buf_valid) begin
            if_id.pc_s      = buf_pc;
            if_id.pc_next_s = next_word(buf_pc);
            if_id.valid_s   = 1'b1;
            inst            = buf_inst;
        end
    end

    resp_only_when_outstanding: assert property (
        @(posedge clk) disable iff (!rst_n)
        imem_resp |-> ((state == FETCH_WAIT) || (state == FETCH_DROP))
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a transaction-level model of the fetch rules checked
// every cycle, a responding instruction memory, directed cases and random traffic.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h1eceb000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             stall = 1'b0;
    logic             flush = 1'b0;
    logic [31:0]      redirect_pc = 32'h0;
    logic [31:0]      imem_addr;
    logic [3:0]       imem_rmask;
    logic [31:0]      imem_rdata = 32'h0;
    logic             imem_resp = 1'b0;
    if_id_stage_reg_t if_id;
    logic [31:0]      inst;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rmask  (imem_rmask),
        .imem_rdata  (imem_rdata),
        .imem_resp   (imem_resp),
        .if_id       (if_id),
        .inst        (inst)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle_no = 0;

    // Memory side
    bit          mem_pending;
    int          mem_wait;
    int          delay_lo;
    int          delay_hi;
    logic [31:0] mem_data;
    logic [31:0] exp_q[$];

    // Model: the address the next request must carry, the in-flight request,
    // the word decode has been offered but not taken, and whether the
    // in-flight request was made obsolete by a redirect.
    logic [31:0] m_next_pc;
    logic [31:0] m_req_pc;
    logic [31:0] m_held_pc;
    logic [31:0] m_held_inst;
    bit          m_held;
    bit          m_stale;
    int          idle;

    logic [31:0] valid_pc_q[$];
    logic [31:0] valid_inst_q[$];
    int          valid_cyc_q[$];
    logic [31:0] accept_q[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cycle_no, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %b, expected %b", name, cycle_no, act, exp);
        end
    endtask

    task automatic clear_logs();
        valid_pc_q.delete();
        valid_inst_q.delete();
        valid_cyc_q.delete();
        accept_q.delete();
    endtask

    function automatic int count_inst(input logic [31:0] v);
        int n = 0;
        foreach (valid_inst_q[i]) if (valid_inst_q[i] == v) n++;
        return n;
    endfunction

    task automatic evaluate();
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        exp_valid = 1'b0;
        exp_pc    = 32'h0;
        exp_inst  = 32'h0;
        if (flush) begin
            exp_valid = 1'b0;
        end else if (imem_resp && !m_stale) begin
            exp_valid = 1'b1;
            exp_pc    = m_req_pc;
            exp_inst  = imem_rdata;
        end else if (m_held) begin
            exp_valid = 1'b1;
            exp_pc    = m_held_pc;
            exp_inst  = m_held_inst;
        end
        check1("valid", if_id.valid_s, exp_valid);
        if (exp_valid) begin
            check32("pc", if_id.pc_s, exp_pc);
            check32("pc_next", if_id.pc_next_s, exp_pc + 32'd4);
            check32("inst", inst, exp_inst);
        end
        if (if_id.valid_s) begin
            valid_pc_q.push_back(if_id.pc_s);
            valid_inst_q.push_back(inst);
            valid_cyc_q.push_back(cycle_no);
        end
        if (m_held) check32("hold_rmask", {28'h0, imem_rmask}, 32'h0);
        if (mem_pending) begin
            check32("inflight_rmask", {28'h0, imem_rmask}, 32'hf);
            check32("inflight_addr", imem_addr, m_req_pc);
        end

        if (flush) begin
            m_next_pc = redirect_pc & ~32'h3;
            m_held    = 1'b0;
            m_stale   = mem_pending && !imem_resp;
        end else if (imem_resp && m_stale) begin
            m_stale = 1'b0;
        end else if (imem_resp) begin
            if (stall) begin
                m_held      = 1'b1;
                m_held_pc   = m_req_pc;
                m_held_inst = imem_rdata;
            end else begin
                m_next_pc = m_req_pc + 32'd4;
            end
        end else if (m_held && !stall) begin
            m_held    = 1'b0;
            m_next_pc = m_held_pc + 32'd4;
        end

        if (imem_resp) begin
            mem_pending = 1'b0;
        end else if (mem_pending) begin
            if (mem_wait > 0) mem_wait--;
        end else if (imem_rmask == 4'hf && !flush) begin
            check32("req_addr", imem_addr, m_next_pc);
            accept_q.push_back(imem_addr);
            m_req_pc    = imem_addr;
            mem_pending = 1'b1;
            mem_wait    = $urandom_range(delay_hi, delay_lo);
            mem_data    = (exp_q.size() > 0) ? exp_q.pop_front() : $urandom;
        end

        if (mem_pending || m_held || flush) idle = 0;
        else idle++;
        check1("progress", idle > 4, 1'b0);
        if (idle > 4) idle = 0;
    endtask

    task automatic step(input logic s, input logic f, input logic [31:0] r);
        @(posedge clk);
        #1;
        stall       = s;
        flush       = f;
        redirect_pc = r;
        if (mem_pending && mem_wait == 0) begin
            imem_resp  = 1'b1;
            imem_rdata = mem_data;
        end else begin
            imem_resp  = 1'b0;
            imem_rdata = $urandom;
        end
        @(negedge clk);
        cycle_no++;
        evaluate();
    endtask

    task automatic apply_reset();
        rst_n       = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        imem_resp   = 1'b0;
        redirect_pc = 32'h0;
        #1;
        check1("rst_valid", if_id.valid_s, 1'b0);
        check32("rst_pc", if_id.pc_s, 32'h0);
        check32("rst_pc_next", if_id.pc_next_s, 32'h0);
        check32("rst_inst", inst, 32'h0);
        check32("rst_rmask", {28'h0, imem_rmask}, 32'h0);
        check32("rst_addr", imem_addr, 32'h1eceb000);
        mem_pending = 1'b0;
        mem_wait    = 0;
        m_held      = 1'b0;
        m_stale     = 1'b0;
        m_next_pc   = RESET_PC;
        m_req_pc    = RESET_PC;
        idle        = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_resp_ready();
        int n = 0;
        while (!(mem_pending && mem_wait == 0) && n < 20) begin
            step(1'b0, 1'b0, 32'h0);
            n++;
        end
        check1("resp_ready_timeout", mem_pending && mem_wait == 0, 1'b1);
    endtask

    task automatic wait_pending();
        int n = 0;
        while (!mem_pending && n < 20) begin
            step(1'b0, 1'b0, 32'h0);
            n++;
        end
        check1("pending_timeout", mem_pending, 1'b1);
    endtask

    initial begin
        delay_lo = 0;
        delay_hi = 0;
        #2;
        apply_reset();

        // Back-to-back fetches with single-cycle memory.
        clear_logs();
        repeat (8) step(1'b0, 1'b0, 32'h0);
        check1("seq_len", valid_pc_q.size() >= 3, 1'b1);
        if (valid_pc_q.size() >= 3) begin
            check32("seq_pc0", valid_pc_q[0], 32'h1eceb000);
            check32("seq_pc1", valid_pc_q[1], 32'h1eceb004);
            check32("seq_pc2", valid_pc_q[2], 32'h1eceb008);
            check32("seq_gap1", valid_cyc_q[1] - valid_cyc_q[0], 32'd2);
            check32("seq_gap2", valid_cyc_q[2] - valid_cyc_q[1], 32'd2);
        end

        // Stall across the response: word held for 4 cycles, no refetch.
        apply_reset();
        clear_logs();
        exp_q.push_back(32'h00a00093);
        wait_resp_ready();
        repeat (3) step(1'b1, 1'b0, 32'h0);
        repeat (4) step(1'b0, 1'b0, 32'h0);
        check32("stall_valid_cycles", count_inst(32'h00a00093), 32'd4);
        check1("stall_accepts", accept_q.size() >= 2, 1'b1);
        if (accept_q.size() >= 2) check32("stall_next_addr", accept_q[1], 32'h1eceb004);

        // Flush while waiting; the stale word must never surface.
        apply_reset();
        clear_logs();
        delay_lo = 2;
        delay_hi = 2;
        exp_q.push_back(32'hdeadbeef);
        wait_pending();
        delay_lo = 0;
        delay_hi = 0;
        step(1'b0, 1'b1, 32'h1eceb100);
        repeat (6) step(1'b0, 1'b0, 32'h0);
        check32("drop_deadbeef", count_inst(32'hdeadbeef), 32'd0);
        check1("drop_accepts", accept_q.size() >= 2, 1'b1);
        if (accept_q.size() >= 2) check32("drop_next_addr", accept_q[1], 32'h1eceb100);

        // Flush in the same cycle as the response.
        apply_reset();
        clear_logs();
        wait_resp_ready();
        step(1'b0, 1'b1, 32'h1eceb200);
        check1("flush_resp_valid", if_id.valid_s, 1'b0);
        repeat (4) step(1'b0, 1'b0, 32'h0);
        check1("flush_resp_accepts", accept_q.size() >= 2, 1'b1);
        if (accept_q.size() >= 2) check32("flush_resp_addr", accept_q[1], 32'h1eceb200);

        // Redirect to the top of the address space and wrap.
        apply_reset();
        clear_logs();
        wait_resp_ready();
        step(1'b0, 1'b1, 32'hfffffffe);
        repeat (6) step(1'b0, 1'b0, 32'h0);
        check1("wrap_accepts", accept_q.size() >= 3, 1'b1);
        if (accept_q.size() >= 3) begin
            check32("wrap_addr0", accept_q[1], 32'hfffffffc);
            check32("wrap_addr1", accept_q[2], 32'h00000000);
        end
        check1("wrap_valid_seen", valid_pc_q.size() >= 1, 1'b1);
        if (valid_pc_q.size() >= 1) check32("wrap_pc", valid_pc_q[0], 32'hfffffffc);

        // Asynchronous reset in the middle of a wait.
        apply_reset();
        delay_lo = 3;
        delay_hi = 3;
        wait_pending();
        step(1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        check32("mid_wait_rmask", {28'h0, imem_rmask}, 32'hf);
        #1;
        delay_lo = 0;
        delay_hi = 0;
        apply_reset();
        clear_logs();
        repeat (4) step(1'b0, 1'b0, 32'h0);
        check1("post_reset_accepts", accept_q.size() >= 1, 1'b1);
        if (accept_q.size() >= 1) check32("post_reset_addr", accept_q[0], 32'h1eceb000);

        // Random traffic.
        apply_reset();
        delay_lo = 0;
        delay_hi = 3;
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 5, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete, expected finish before 1000000");
        $fatal(1, "timeout");
    end

endmodule
